truth_table_checker: RTL and testbench
======================================

# truth_table_checker

Parametrised sequential equivalence checker for N-input combinational functions. It sweeps every input vector 0 to 2^N-1 on `stim` and samples two single-bit responses: `resp_a` from the reference (unminimised) circuit and `resp_b` from the circuit under check (minimised). It captures the full truth table of `resp_a` and reports the mismatch count, the first failing vector and an overall pass flag. It is the clocked, self-checking replacement for hand-written truth-table sweeps in exercise benches.

## Interface
- `N`, default 3: number of function inputs; valid range 1..8.
- `SETTLE`, default 1: cycles each vector is held before sampling; valid range 1..15.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a sweep; accepted only in IDLE or DONE.
- `resp_a`  in  1: reference circuit output for the current `stim`.
- `resp_b`  in  1: circuit-under-check output for the current `stim`.
- `stim`  out  N: input vector driven to both circuits.
- `busy`  out  1: sweep in progress.
- `done`  out  1: one-cycle pulse at the end of a sweep.
- `pass`  out  1: last completed sweep had zero mismatches.
- `mismatch_cnt`  out  N+1: number of vectors where `resp_a` != `resp_b`.
- `first_bad`  out  N: lowest failing vector; valid only when `first_valid`=1.
- `first_valid`  out  1: at least one mismatch was recorded.
- `table_a`  out  2^N: captured truth table; bit v = `resp_a` at `stim`=v.

## Operation
- Reset: state IDLE. `stim`, `busy`, `done`, `pass`, `mismatch_cnt`, `first_bad`, `first_valid` and `table_a` all read 0.
- FSM states:
  - IDLE -> DRIVE on `start`.
  - DRIVE: hold for SETTLE cycles, then -> SAMPLE.
  - SAMPLE: at the last vector -> DONE; otherwise increment `stim` and -> DRIVE.
  - DONE: one cycle, then -> IDLE; `start` in DONE -> DRIVE.
- On start acceptance:
  - `stim`, `mismatch_cnt`, `first_bad`, `first_valid`, `table_a` and `pass` clear to 0.
  - `busy` goes to 1.
- SAMPLE edge:
  - `table_a[stim]` <= `resp_a`.
  - If `resp_a` != `resp_b`: `mismatch_cnt` increments. If `first_valid`=0, then `first_bad` <= `stim` and `first_valid` <= 1.
- End of sweep:
  - `stim` wraps to 0 and `busy` drops to 0.
  - `done`=1 for exactly one cycle.
  - `pass` <= (final `mismatch_cnt`==0).
- Results hold until the next accepted `start` or reset.
- `mismatch_cnt` is N+1 bits wide, so 2^N mismatches never overflow.
- `start` while `busy`=1 is ignored and has no effect on the sweep.
- `rst_n` low mid-sweep aborts immediately to reset values; partial results are discarded.

## Timing
- Each vector occupies SETTLE+1 cycles: SETTLE in DRIVE, 1 in SAMPLE.
- Responses are sampled on the rising edge that ends SAMPLE.
- `start` high at edge k puts `stim`=0 and `busy`=1 after edge k.
- The sweep lasts 2^N*(SETTLE+1) cycles. `done` is high in the following cycle, when all results are already valid.
- `resp_a` and `resp_b` must be stable within SETTLE+1 cycles of a `stim` change. The block does not register them before sampling.

## Configuration
- `TTC_STOP_ON_FAIL_EN`:
  - Defined: the first mismatch ends the sweep. At that SAMPLE edge the FSM goes to DONE, `mismatch_cnt`=1 and `first_bad` holds the failing vector. `table_a` bits above the failing vector remain 0. `stim` returns to 0.
  - Undefined: the full sweep always runs.

## Test plan
All scenarios use N=3, SETTLE=2.
- Equivalent functions: `resp_a` = a'b'c+a'bc'+a'bc+ab'c and `resp_b` = a'bc'+ab'c+a'c, with stim[2]=a. Expect `done` 25 cycles after start, `pass`=1, `mismatch_cnt`=0, `first_valid`=0, `table_a`=8'h2E.
- Faulty `resp_b` = a'bc'+ab'c (table 8'h24). Expect `pass`=0, `mismatch_cnt`=2, `first_bad`=3'b001, `first_valid`=1, `table_a`=8'h2E.
- `resp_b` = ~`resp_a`. Expect `mismatch_cnt`=8 (4'b1000, no overflow) and `first_bad`=0.
- Pulse `start` at cycle 5 of a sweep. Expect no restart, `done` still at cycle 25, and results unchanged.
- Drop `rst_n` at cycle 10. Expect all outputs 0 asynchronously; after release, a new `start` gives the correct full result.
- With `TTC_STOP_ON_FAIL_EN` and the faulty `resp_b`: expect `done` 7 cycles after start, `mismatch_cnt`=1, `first_bad`=3'b001, `table_a`=8'h02.

Source files
------------

// File: rtl/truth_table_checker.sv
// Sweeps stim 0..2^N-1 and compares resp_a against resp_b. With TTC_STOP_ON_FAIL_EN defined, the first mismatch ends the sweep.
// A sweep takes 2^N*(SETTLE+1) cycles and done pulses in the next cycle. start is ignored while busy; there is no other backpressure.
module truth_table_checker #(
  parameter int N      = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 resp_a,
  input  logic                 resp_b,
  output logic [N-1:0]         stim,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N:0]           mismatch_cnt,
  output logic [N-1:0]         first_bad,
  output logic                 first_valid,
  output logic [(1<<N)-1:0]    table_a
);

  localparam int            TW          = 1 << N;
  localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [N-1:0]  STIM_LAST   = {N{1'b1}};

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      settle_q, settle_d;
  logic [N-1:0]    stim_q, stim_d;
  logic [N:0]      cnt_q, cnt_d;
  logic [N-1:0]    first_bad_q, first_bad_d;
  logic            first_valid_q, first_valid_d;
  logic [TW-1:0]   table_q, table_d;
  logic            pass_q, pass_d;
  logic            mism;
  logic            sweep_end;

  assign mism = resp_a ^ resp_b;

  always_comb begin
    state_d       = state_q;
    settle_d      = settle_q;
    stim_d        = stim_q;
    cnt_d         = cnt_q;
    first_bad_d   = first_bad_q;
    first_valid_d = first_valid_q;
    table_d       = table_q;
    pass_d        = pass_q;
    sweep_end     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d       = DRIVE;
          settle_d      = '0;
          stim_d        = '0;
          cnt_d         = '0;
          first_bad_d   = '0;
          first_valid_d = 1'b0;
          table_d       = '0;
          pass_d        = 1'b0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      SAMPLE: begin
        table_d[stim_q] = resp_a;
        if (mism) begin
          cnt_d = cnt_q + 1'b1;
          if (!first_valid_q) begin
            first_bad_d   = stim_q;
            first_valid_d = 1'b1;
          end
        end
        settle_d  = '0;
        sweep_end = (stim_q == STIM_LAST);
`ifdef TTC_STOP_ON_FAIL_EN
        sweep_end = sweep_end | mism;
`else
        sweep_end = sweep_end | 1'b0;
`endif
        if (sweep_end) begin
          state_d = DONE;
          stim_d  = '0;
          // This sample's mismatch is not in cnt_q yet, so fold it in here.
          pass_d  = (cnt_q == '0) && !mism;
        end else begin
          state_d = DRIVE;
          stim_d  = stim_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      settle_q      <= '0;
      stim_q        <= '0;
      cnt_q         <= '0;
      first_bad_q   <= '0;
      first_valid_q <= 1'b0;
      table_q       <= '0;
      pass_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      stim_q        <= stim_d;
      cnt_q         <= cnt_d;
      first_bad_q   <= first_bad_d;
      first_valid_q <= first_valid_d;
      table_q       <= table_d;
      pass_q        <= pass_d;
    end
  end

  assign stim         = stim_q;
  assign busy         = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done         = (state_q == DONE);
  assign pass         = pass_q;
  assign mismatch_cnt = cnt_q;
  assign first_bad    = first_bad_q;
  assign first_valid  = first_valid_q;
  assign table_a      = table_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker at N=3, SETTLE=2: table-driven sweeps with a result scoreboard, plus reset-abort sequence.
module tb_truth_table_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       resp_a;
  logic       resp_b;
  logic [2:0] stim;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] mismatch_cnt;
  logic [2:0] first_bad;
  logic       first_valid;
  logic [7:0] table_a;

  int mode;
  int errors;
  int checks;

  typedef struct {
    int         mode;
    bit         inject;
    int         lat;
    logic       pass;
    logic [3:0] cnt;
    logic [2:0] fb;
    logic       fv;
    logic [7:0] tbl;
  } vec_t;

  vec_t vecs[4];
  vec_t exp_q[$];

  truth_table_checker #(.N(3), .SETTLE(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .resp_a       (resp_a),
    .resp_b       (resp_b),
    .stim         (stim),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .mismatch_cnt (mismatch_cnt),
    .first_bad    (first_bad),
    .first_valid  (first_valid),
    .table_a      (table_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a = stim[2], b = stim[1], c = stim[0]
  logic a, b, c;
  always_comb begin
    a      = stim[2];
    b      = stim[1];
    c      = stim[0];
    resp_a = (!a & !b & c) | (!a & b & !c) | (!a & b & c) | (a & !b & c);
    case (mode)
      0:       resp_b = (!a & b & !c) | (a & !b & c) | (!a & c);
      1:       resp_b = (!a & b & !c) | (a & !b & c);
      default: resp_b = !resp_a;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_sweep(input vec_t v);
    int   edges;
    vec_t e;
    mode = v.mode;
    @(posedge clk); #1;
    start = 1'b1;
    exp_q.push_back(v);
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    chk("stim_after_start", 32'(stim), 32'd0);
    chk("busy_after_start", 32'(busy), 32'd1);
    while (!done && edges < 200) begin
      @(posedge clk); #1;
      edges++;
      if (v.inject && edges == 5) start = 1'b1;
      if (edges == 6) start = 1'b0;
    end
    e = exp_q.pop_front();
    if (!done) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("done_latency", 32'(edges), 32'(e.lat));
      chk("pass", 32'(pass), 32'(e.pass));
      chk("mismatch_cnt", 32'(mismatch_cnt), 32'(e.cnt));
      chk("first_bad", 32'(first_bad), 32'(e.fb));
      chk("first_valid", 32'(first_valid), 32'(e.fv));
      chk("table_a", 32'(table_a), 32'(e.tbl));
      chk("stim_wrapped", 32'(stim), 32'd0);
      chk("busy_at_done", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(done), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("hold_cnt", 32'(mismatch_cnt), 32'(e.cnt));
      chk("hold_table", 32'(table_a), 32'(e.tbl));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stim"}, 32'(stim), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_cnt"}, 32'(mismatch_cnt), 32'd0);
    chk({tag, "_first_bad"}, 32'(first_bad), 32'd0);
    chk({tag, "_first_valid"}, 32'(first_valid), 32'd0);
    chk({tag, "_table"}, 32'(table_a), 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    mode   = 0;
    start  = 1'b0;
    rst_n  = 1'b0;

    vecs[0] = '{mode: 0, inject: 1'b0, lat: 25, pass: 1'b1, cnt: 4'd0, fb: 3'd0, fv: 1'b0, tbl: 8'h2E};
`ifdef TTC_STOP_ON_FAIL_EN
    vecs[1] = '{mode: 1, inject: 1'b0, lat: 7, pass: 1'b0, cnt: 4'd1, fb: 3'd1, fv: 1'b1, tbl: 8'h02};
    vecs[2] = '{mode: 2, inject: 1'b0, lat: 4, pass: 1'b0, cnt: 4'd1, fb: 3'd0, fv: 1'b1, tbl: 8'h00};
    vecs[3] = '{mode: 1, inject: 1'b1, lat: 7, pass: 1'b0, cnt: 4'd1, fb: 3'd1, fv: 1'b1, tbl: 8'h02};
`else
    vecs[1] = '{mode: 1, inject: 1'b0, lat: 25, pass: 1'b0, cnt: 4'd2, fb: 3'd1, fv: 1'b1, tbl: 8'h2E};
    vecs[2] = '{mode: 2, inject: 1'b0, lat: 25, pass: 1'b0, cnt: 4'd8, fb: 3'd0, fv: 1'b1, tbl: 8'h2E};
    vecs[3] = '{mode: 1, inject: 1'b1, lat: 25, pass: 1'b0, cnt: 4'd2, fb: 3'd1, fv: 1'b1, tbl: 8'h2E};
`endif

    #12;
    chk_reset_vals("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run_sweep(vecs[i]);
    end

    // Abort a faulty sweep at cycle 10 with an asynchronous reset.
    mode = 1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    #3;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_abort", 32'(busy), 32'd0);
    run_sweep(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
